// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin arbiter sharing the register file's single write port
//            between NUM_REQ writeback sources, with a pending-write
//            scoreboard for issue-side WAW/RAW hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_req_valid,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  in_req_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_data,
  output logic [NUM_REQ-1:0]            out_req_ready,
  input  logic                          in_claim_en,
  input  logic [SEL_WIDTH-1:0]          in_claim_sel,
  output logic                          out_claim_ok,
  output logic [NUM_REGS-1:0]           out_pending,
  output logic                          out_write_en,
  output logic [SEL_WIDTH-1:0]          out_write_sel,
  output logic [DATA_WIDTH-1:0]         out_write_data,
  output logic                          out_err
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_PTR_W-1:0]    r_rr_ptr;
  logic                  w_found;
  int                    w_gidx;
  int                    w_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_claim_set;
  logic                  w_write_nz;
  logic [NUM_REGS-1:0]   w_pending_nxt;

  // Round-robin search starting at r_rr_ptr; first valid requester wins
  always_comb begin
    w_found = 1'b0;
    w_gidx  = 0;
    w_idx   = 0;
    w_grant = '0;
    w_sel   = '0;
    w_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && in_req_valid[w_idx]) begin
        w_found         = 1'b1;
        w_gidx          = w_idx;
        w_grant[w_idx]  = 1'b1;
        w_sel           = in_req_sel[w_idx*SEL_WIDTH +: SEL_WIDTH];
        w_data          = in_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_req_ready = w_grant;

  // r0 writes are granted but never reach the register file
  assign w_write_nz = w_found && (w_sel != '0);

  // A write landing on the claimed register this cycle frees it for reclaim
  assign out_claim_ok = (in_claim_sel == '0) || !out_pending[in_claim_sel] ||
                        (out_write_en && (out_write_sel == in_claim_sel));

  assign w_claim_set = in_claim_en && out_claim_ok && (in_claim_sel != '0);

  // Scoreboard next state: commit clears, new claim sets and takes priority
  always_comb begin
    w_pending_nxt = out_pending;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (out_write_en && (out_write_sel == SEL_WIDTH'(r))) begin
        w_pending_nxt[r] = 1'b0;
      end
      if (w_claim_set && (in_claim_sel == SEL_WIDTH'(r))) begin
        w_pending_nxt[r] = 1'b1;
      end
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Advance the round-robin pointer past the requester just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= c_PTR_W'((w_gidx + 1) % NUM_REQ);
    end
  end

  // Registered write port; sel/data hold when nothing is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_write_en   <= 1'b0;
      out_write_sel  <= '0;
      out_write_data <= '0;
    end else begin
      out_write_en <= w_write_nz;
      if (w_write_nz) begin
        out_write_sel  <= w_sel;
        out_write_data <= w_data;
      end
    end
  end

  // Pending scoreboard and sticky error for writes to unreserved registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pending <= '0;
      out_err     <= 1'b0;
    end else begin
      out_pending <= w_pending_nxt;
      if (w_write_nz && !out_pending[w_sel] &&
          !(w_claim_set && (in_claim_sel == w_sel))) begin
        out_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int NUM_REGS   = 16;
  localparam int SEL_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NUM_REQ-1:0]            in_req_valid = '0;
  logic [NUM_REQ*SEL_WIDTH-1:0]  in_req_sel = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_data = '0;
  logic [NUM_REQ-1:0]            out_req_ready;
  logic                          in_claim_en = 1'b0;
  logic [SEL_WIDTH-1:0]          in_claim_sel = '0;
  logic                          out_claim_ok;
  logic [NUM_REGS-1:0]           out_pending;
  logic                          out_write_en;
  logic [SEL_WIDTH-1:0]          out_write_sel;
  logic [DATA_WIDTH-1:0]         out_write_data;
  logic                          out_err;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_req_valid  (in_req_valid),
    .in_req_sel    (in_req_sel),
    .in_req_data   (in_req_data),
    .out_req_ready (out_req_ready),
    .in_claim_en   (in_claim_en),
    .in_claim_sel  (in_claim_sel),
    .out_claim_ok  (out_claim_ok),
    .out_pending   (out_pending),
    .out_write_en  (out_write_en),
    .out_write_sel (out_write_sel),
    .out_write_data(out_write_data),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_rdy;
    // ---------------- reset state
    #2;
    chk("rst_we",   64'(out_write_en), 64'h0);
    chk("rst_sel",  64'(out_write_sel), 64'h0);
    chk("rst_data", 64'(out_write_data), 64'h0);
    chk("rst_pend", 64'(out_pending), 64'h0);
    chk("rst_err",  64'(out_err), 64'h0);
    chk("rst_rdy",  64'(out_req_ready), 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // ---------------- claim r5, req1 writes DEADBEEF
    in_claim_en = 1'b1; in_claim_sel = 4'd5;
    #1 chk("b_claim_ok", 64'(out_claim_ok), 64'h1);
    tick();
    in_claim_en = 1'b0;
    chk("b_pend_set", 64'(out_pending), 64'h0020);
    in_req_valid = 3'b010;
    in_req_sel   = {4'd0, 4'd5, 4'd0};
    in_req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
    #1 chk("b_ready", 64'(out_req_ready), 64'h2);
    tick();
    in_req_valid = '0;
    #1;
    chk("b_we",   64'(out_write_en), 64'h1);
    chk("b_sel",  64'(out_write_sel), 64'h5);
    chk("b_data", 64'(out_write_data), 64'hDEADBEEF);
    chk("b_pend_hold", 64'(out_pending), 64'h0020);
    tick();
    chk("b_pend_clr", 64'(out_pending), 64'h0);
    chk("b_we_off",   64'(out_write_en), 64'h0);
    chk("b_err",      64'(out_err), 64'h0);

    // ---------------- r0 write from req2 (pointer now at 2)
    in_req_valid = 3'b100;
    in_req_sel   = {4'd0, 4'd0, 4'd0};
    in_req_data  = {32'h12345678, 32'h0, 32'h0};
    #1 chk("c_ready", 64'(out_req_ready), 64'h4);
    tick();
    in_req_valid = '0;
    #1;
    chk("c_we",   64'(out_write_en), 64'h0);
    chk("c_sel",  64'(out_write_sel), 64'h5);
    chk("c_data", 64'(out_write_data), 64'hDEADBEEF);
    chk("c_err",  64'(out_err), 64'h0);
    chk("c_pend", 64'(out_pending), 64'h0);

    // ---------------- r7 set/clear collision (pointer now at 0)
    in_claim_en = 1'b1; in_claim_sel = 4'd7;
    tick();
    in_claim_en = 1'b0;
    chk("d_pend", 64'(out_pending), 64'h0080);
    in_req_valid = 3'b001;
    in_req_sel   = {4'd0, 4'd0, 4'd7};
    in_req_data  = {32'h0, 32'h0, 32'h77};
    #1 chk("d_ready", 64'(out_req_ready), 64'h1);
    tick();
    in_req_valid = '0;
    in_claim_en = 1'b1; in_claim_sel = 4'd7;
    #1;
    chk("d_we",       64'(out_write_en), 64'h1);
    chk("d_sel",      64'(out_write_sel), 64'h7);
    chk("d_claim_ok", 64'(out_claim_ok), 64'h1);
    tick();
    in_claim_en = 1'b0;
    #1;
    chk("d_pend_keep", 64'(out_pending), 64'h0080);
    chk("d_err",       64'(out_err), 64'h0);

    // ---------------- unclaimed r9 write (pointer now at 1)
    in_req_valid = 3'b010;
    in_req_sel   = {4'd0, 4'd9, 4'd0};
    in_req_data  = {32'h0, 32'h99, 32'h0};
    #1 chk("e_ready", 64'(out_req_ready), 64'h2);
    tick();
    in_req_valid = '0;
    #1;
    chk("e_we",  64'(out_write_en), 64'h1);
    chk("e_sel", 64'(out_write_sel), 64'h9);
    chk("e_err", 64'(out_err), 64'h1);
    // legal write of claimed r7 from req2
    in_req_valid = 3'b100;
    in_req_sel   = {4'd7, 4'd0, 4'd0};
    in_req_data  = {32'h7, 32'h0, 32'h0};
    #1 chk("e_ready2", 64'(out_req_ready), 64'h4);
    tick();
    in_req_valid = '0;
    #1;
    chk("e_err_sticky", 64'(out_err), 64'h1);
    tick();
    chk("e_pend_clr",  64'(out_pending), 64'h0);
    chk("e_err_still", 64'(out_err), 64'h1);

    // ---------------- reset while writing with pending=00F0 (pointer at 0)
    for (int r = 4; r < 8; r++) begin
      in_claim_en = 1'b1; in_claim_sel = 4'(r);
      tick();
    end
    in_claim_en = 1'b0;
    chk("f_pend", 64'(out_pending), 64'h00F0);
    in_req_valid = 3'b001;
    in_req_sel   = {4'd0, 4'd0, 4'd4};
    in_req_data  = {32'h0, 32'h0, 32'h44};
    #1 chk("f_ready", 64'(out_req_ready), 64'h1);
    tick();
    in_req_valid = '0;
    #1 chk("f_we", 64'(out_write_en), 64'h1);
    rst = 1'b1;
    #1;
    chk("f_rst_we",   64'(out_write_en), 64'h0);
    chk("f_rst_sel",  64'(out_write_sel), 64'h0);
    chk("f_rst_data", 64'(out_write_data), 64'h0);
    chk("f_rst_pend", 64'(out_pending), 64'h0);
    chk("f_rst_err",  64'(out_err), 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // ---------------- all three held valid: grants 0,1,2,0,1,2
    in_req_valid = 3'b111;
    in_req_sel   = {4'd3, 4'd2, 4'd1};
    in_req_data  = {32'h33, 32'h22, 32'h11};
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy = 3'b001 << (i % 3);
      chk("g_ready", 64'(out_req_ready), 64'(exp_rdy));
      tick();
      chk("g_we",   64'(out_write_en), 64'h1);
      chk("g_sel",  64'(out_write_sel), 64'((i % 3) + 1));
      chk("g_data", 64'(out_write_data), 64'(((i % 3) + 1) * 32'h11));
    end
    in_req_valid = '0;
    tick();
    chk("g_we_off", 64'(out_write_en), 64'h0);
    chk("g_sel_hold", 64'(out_write_sel), 64'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
